// File: rtl/pc_stack_unit_if.sv
// Fetch-side bus of the PC/return-stack unit.
// The control inputs go to the PC; the PC, link address and stack status come back.
interface pc_stack_unit_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
);
  logic               stall;
  logic [1:0]         select;
  logic [ADDR_W-1:0]  jump_adress;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  pc_out2;
  logic               stack_empty;
  logic               stack_full;
  logic               stack_err;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output stall, select, jump_adress,
    input  pc_out, pc_out2, stack_empty, stack_full, stack_err, depth
  );
  modport slave (
    input  stall, select, jump_adress,
    output pc_out, pc_out2, stack_empty, stack_full, stack_err, depth
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a LIFO return-address stack.
// Supports increment, jump, call and return, plus stall and a sticky stack-error flag.
module pc_stack_unit #(
  parameter int              ADDR_W      = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  pc_stack_unit_if.slave  bus
);
  typedef enum logic [1:0] {OP_INC = 2'b00, OP_JUMP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_e;

  logic [ADDR_W-1:0]  r_pc;
  logic [DEPTH_W-1:0] r_sp;
  logic               r_err;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0]  w_pc_inc, w_pc_nxt;
  logic [DEPTH_W-1:0] w_sp_nxt;
  logic               w_err_nxt, w_push, w_full, w_empty;
  logic [IDX_W-1:0]   w_push_idx, w_pop_idx;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_full     = (r_sp == DEPTH_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  // Both indices only get used when they are in range (not full / not empty).
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - DEPTH_W'(1));

  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_err_nxt = r_err;
    w_push    = 1'b0;
    if (!bus.stall) begin
      unique case (op_e'(bus.select))
        OP_INC:  w_pc_nxt = w_pc_inc;
        OP_JUMP: w_pc_nxt = bus.jump_adress;
        OP_CALL: begin
          if (w_full) begin
            w_pc_nxt  = w_pc_inc;
            w_err_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + DEPTH_W'(1);
            w_pc_nxt = bus.jump_adress;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_pc_nxt  = w_pc_inc;
            w_err_nxt = 1'b1;
          end else begin
            w_sp_nxt = r_sp - DEPTH_W'(1);
            w_pc_nxt = r_stack[w_pop_idx];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_ADDR;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
      if (w_push) r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.pc_out2     = w_pc_inc;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.stack_err   = r_err;
  assign bus.depth       = r_sp;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_pc_stack_unit;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer mod 256, return stack as a queue.
  int         m_pc = 0;
  int         m_stk[$];
  bit         m_err = 0;
  bit         m_vld = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 0;
      m_vld = 1;
    end else if (m_vld && !bus.stall) begin
      case (bus.select)
        2'b00: m_pc = (m_pc + 1) % 256;
        2'b01: m_pc = int'(bus.jump_adress);
        2'b10: if (m_stk.size() < DEPTH) begin
                 m_stk.push_back((m_pc + 1) % 256);
                 m_pc = int'(bus.jump_adress);
               end else begin
                 m_pc = (m_pc + 1) % 256;
                 m_err = 1;
               end
        default: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                 else begin
                   m_pc = (m_pc + 1) % 256;
                   m_err = 1;
                 end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_vld) begin
      chk("pc_out",      int'(bus.pc_out),      m_pc);
      chk("pc_out2",     int'(bus.pc_out2),     (m_pc + 1) % 256);
      chk("depth",       int'(bus.depth),       m_stk.size());
      chk("stack_empty", int'(bus.stack_empty), int'(m_stk.size() == 0));
      chk("stack_full",  int'(bus.stack_full),  int'(m_stk.size() == DEPTH));
      chk("stack_err",   int'(bus.stack_err),   int'(m_err));
    end
  end

  task automatic step(input logic r, input logic s, input logic [1:0] sel, input logic [7:0] a);
    @(negedge clk);
    rst             = r;
    bus.stall       = s;
    bus.select      = sel;
    bus.jump_adress = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.select = 2'b00; bus.jump_adress = '0;

    // 1) reset then INC x5
    step(1, 0, 2'b00, 8'h00);
    step(1, 0, 2'b00, 8'h00);
    chk("rst_pc", int'(bus.pc_out), 0);
    chk("rst_empty", int'(bus.stack_empty), 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 2'b00, 8'h00);
      chk("inc_pc", int'(bus.pc_out), i);
    end
    chk("inc_pc2", int'(bus.pc_out2), 6);

    // 2) jump, stall, wrap
    step(0, 0, 2'b01, 8'h56);
    chk("jump_pc", int'(bus.pc_out), 'h56);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 8'h99);
    chk("stall_pc", int'(bus.pc_out), 'h56);
    step(0, 0, 2'b01, 8'hFE);
    step(0, 0, 2'b00, 8'h00);
    chk("wrap_ff", int'(bus.pc_out), 'hFF);
    chk("wrap_ff2", int'(bus.pc_out2), 'h00);
    step(0, 0, 2'b00, 8'h00);
    chk("wrap_00", int'(bus.pc_out), 'h00);
    chk("wrap_01", int'(bus.pc_out2), 'h01);

    // 3) nested calls
    step(0, 0, 2'b01, 8'h10);
    step(0, 0, 2'b10, 8'h40);
    step(0, 0, 2'b10, 8'h80);
    chk("call_pc", int'(bus.pc_out), 'h80);
    chk("call_depth", int'(bus.depth), 2);
    step(0, 0, 2'b11, 8'h00);
    chk("ret1_pc", int'(bus.pc_out), 'h41);
    step(0, 0, 2'b11, 8'h00);
    chk("ret2_pc", int'(bus.pc_out), 'h11);
    chk("ret_empty", int'(bus.stack_empty), 1);
    chk("ret_err", int'(bus.stack_err), 0);

    // 4) overflow
    step(1, 0, 2'b00, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 2'b10, 8'h20);
    chk("ovf_pc", int'(bus.pc_out), 'h21);
    chk("ovf_depth", int'(bus.depth), 4);
    chk("ovf_full", int'(bus.stack_full), 1);
    chk("ovf_err", int'(bus.stack_err), 1);
    step(0, 0, 2'b11, 8'h00);
    chk("ovf_ret_pc", int'(bus.pc_out), 'h21);
    chk("ovf_ret_depth", int'(bus.depth), 3);
    chk("ovf_err_sticky", int'(bus.stack_err), 1);

    // 5) underflow
    step(1, 0, 2'b00, 8'h00);
    step(0, 0, 2'b11, 8'h00);
    chk("unf_pc", int'(bus.pc_out), 1);
    chk("unf_depth", int'(bus.depth), 0);
    chk("unf_err", int'(bus.stack_err), 1);
    step(0, 1, 2'b11, 8'h00);
    chk("unf_stall_pc", int'(bus.pc_out), 1);

    // 6) reset mid-operation beats stall and CALL
    step(0, 0, 2'b10, 8'h30);
    step(0, 0, 2'b10, 8'h31);
    step(0, 0, 2'b10, 8'h32);
    chk("pre_rst_depth", int'(bus.depth), 3);
    chk("pre_rst_err", int'(bus.stack_err), 1);
    step(1, 1, 2'b10, 8'h77);
    chk("mid_rst_pc", int'(bus.pc_out), 0);
    chk("mid_rst_depth", int'(bus.depth), 0);
    chk("mid_rst_err", int'(bus.stack_err), 0);
    step(0, 0, 2'b00, 8'h00);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
